// File: rtl/mmio_uart_tx_pkg.sv
// rtl/mmio_uart_tx_pkg.sv - shared register map, bit indices and TX state encoding
package mmio_uart_tx_pkg;

  // Register offsets inside the 4-byte window
  localparam logic [1:0] OFF_TXDATA = 2'd0;
  localparam logic [1:0] OFF_STATUS = 2'd1;
  localparam logic [1:0] OFF_DIV    = 2'd2;
  localparam logic [1:0] OFF_CTRL   = 2'd3;

  // STATUS bit positions
  localparam int STAT_FULL_B  = 0;
  localparam int STAT_EMPTY_B = 1;
  localparam int STAT_BUSY_B  = 2;
  localparam int STAT_OVF_B   = 3;

  // CTRL bit positions
  localparam int CTRL_EN_B    = 0;
  localparam int CTRL_FLUSH_B = 1;
  localparam int CTRL_IRQEN_B = 2;

  typedef enum logic [1:0] {
    TX_IDLE  = 2'd0,
    TX_START = 2'd1,
    TX_DATA  = 2'd2,
    TX_STOP  = 2'd3
  } tx_state_t;

endpackage

// File: rtl/mmio_uart_tx_if.sv
// rtl/mmio_uart_tx_if.sv - CPU memory-side bus seen by the UART responder
interface mmio_uart_tx_if;
  logic [15:0] Addr;
  logic [7:0]  MemDataIn;
  logic [7:0]  MemDataOut;
  logic        MemDataOE;
  logic        MemBridge_Load;
  logic        MemBridge_Direction;
  logic        Memory_Ack;

  modport master (
    output Addr, MemDataIn, MemBridge_Load, MemBridge_Direction, Memory_Ack,
    input  MemDataOut, MemDataOE
  );

  modport slave (
    input  Addr, MemDataIn, MemBridge_Load, MemBridge_Direction, Memory_Ack,
    output MemDataOut, MemDataOE
  );
endinterface

// File: rtl/mmio_uart_tx_sync_fifo.sv
// rtl/mmio_uart_tx_sync_fifo.sv - single-clock FIFO with wrap-bit pointers and flush
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 8
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             push,
  input  logic             pop,
  input  logic             flush,
  input  logic [WIDTH-1:0] wdata,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty
);
  localparam int AW = $clog2(DEPTH);

  logic [AW:0]      wr_ptr;
  logic [AW:0]      rd_ptr;
  logic [WIDTH-1:0] mem [DEPTH];
  logic             do_push;
  logic             do_pop;

  assign empty   = (wr_ptr == rd_ptr);
  assign full    = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
  // A push into a full FIFO is still accepted when a pop frees the slot on the same edge
  assign do_push = push && (!full || pop);
  assign do_pop  = pop && !empty;
  assign rdata   = mem[rd_ptr[AW-1:0]];

  // Pointer update; flush wins over any same-cycle push so the FIFO ends empty
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else if (flush) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
    end else begin
      if (do_push) wr_ptr <= wr_ptr + 1'b1;
      if (do_pop)  rd_ptr <= rd_ptr + 1'b1;
    end
  end

  // Storage array, no reset needed since empty pointers hide stale contents
  always_ff @(posedge clk) begin
    if (do_push && !flush) mem[wr_ptr[AW-1:0]] <= wdata;
  end
endmodule

// File: rtl/mmio_uart_tx.sv
// rtl/mmio_uart_tx.sv - memory-mapped 8N1 UART transmitter with TX FIFO
module mmio_uart_tx
  import mmio_uart_tx_pkg::*;
#(
  parameter logic [15:0] BASE_ADDR   = 16'hFF00,
  parameter int          FIFO_DEPTH  = 8,
  parameter logic [7:0]  DEFAULT_DIV = 8'd103
) (
  input  logic           MAINCLK,
  input  logic           MAINRST,
  mmio_uart_tx_if.slave  bus,
  output logic           UartTx,
  output logic           Irq_n
);
  localparam logic [1:0] S_IDLE  = TX_IDLE;
  localparam logic [1:0] S_START = TX_START;
  localparam logic [1:0] S_DATA  = TX_DATA;
  localparam logic [1:0] S_STOP  = TX_STOP;

  logic       sel;
  logic [1:0] offset;
  logic       load_q;
  logic       wr_ev;
  logic       push;
  logic       flush;
  logic       pop;
  logic       start_ok;
  logic       bit_end;
  logic [7:0] div_q;
  logic       enable_q;
  logic       irq_en_q;
  logic       ovf_q;
  logic [1:0] state;
  logic [7:0] cnt;
  logic [2:0] bit_idx;
  logic [7:0] shift;
  logic [7:0] fifo_rdata;
  logic       fifo_full;
  logic       fifo_empty;
  logic [7:0] status;

  assign sel    = (bus.Addr[15:2] == BASE_ADDR[15:2]);
  assign offset = bus.Addr[1:0];

  // One write per falling strobe: only the first sampled-low cycle counts
  assign wr_ev    = sel && !bus.MemBridge_Direction && !bus.MemBridge_Load && load_q;
  assign push     = wr_ev && (offset == OFF_TXDATA);
  assign flush    = wr_ev && (offset == OFF_CTRL) && bus.MemDataIn[CTRL_FLUSH_B];
  assign bit_end  = (cnt == 8'd0);
  assign start_ok = enable_q && !fifo_empty;
  assign pop      = start_ok && ((state == S_IDLE) || ((state == S_STOP) && bit_end));

  sync_fifo #(.WIDTH(8), .DEPTH(FIFO_DEPTH)) u_fifo (
    .clk   (MAINCLK),
    .rst_n (MAINRST),
    .push  (push),
    .pop   (pop),
    .flush (flush),
    .wdata (bus.MemDataIn),
    .rdata (fifo_rdata),
    .full  (fifo_full),
    .empty (fifo_empty)
  );

  // Strobe history for the write edge detector; idles high
  always_ff @(posedge MAINCLK or negedge MAINRST) begin
    if (!MAINRST) load_q <= 1'b1;
    else          load_q <= bus.MemBridge_Load;
  end

  // DIV/CTRL registers and the sticky overflow flag
  always_ff @(posedge MAINCLK or negedge MAINRST) begin
    if (!MAINRST) begin
      div_q    <= DEFAULT_DIV;
      enable_q <= 1'b1;
      irq_en_q <= 1'b0;
      ovf_q    <= 1'b0;
    end else begin
      if (wr_ev && (offset == OFF_DIV)) div_q <= bus.MemDataIn;
      if (wr_ev && (offset == OFF_CTRL)) begin
        enable_q <= bus.MemDataIn[CTRL_EN_B];
        irq_en_q <= bus.MemDataIn[CTRL_IRQEN_B];
      end
      if (!bus.Memory_Ack && sel && (offset == OFF_STATUS)) ovf_q <= 1'b0;
      // A dropped byte outranks a same-cycle clear so the loss is never hidden
      if (push && fifo_full && !pop) ovf_q <= 1'b1;
    end
  end

  // Read path: purely combinational, zero when the window is not addressed
  always_comb begin
    status                = 8'h00;
    status[STAT_FULL_B]   = fifo_full;
    status[STAT_EMPTY_B]  = fifo_empty;
    status[STAT_BUSY_B]   = (state != S_IDLE);
    status[STAT_OVF_B]    = ovf_q;
    bus.MemDataOE         = sel && bus.MemBridge_Direction;
    bus.MemDataOut        = 8'h00;
    if (sel) begin
      case (offset)
        OFF_STATUS: bus.MemDataOut = status;
        OFF_DIV:    bus.MemDataOut = div_q;
        OFF_CTRL:   bus.MemDataOut = {5'b0, irq_en_q, 1'b0, enable_q};
        default:    bus.MemDataOut = 8'h00;
      endcase
    end
  end

  // TX framing FSM; the line level is registered alongside each state change
  always_ff @(posedge MAINCLK or negedge MAINRST) begin
    if (!MAINRST) begin
      state   <= S_IDLE;
      cnt     <= 8'd0;
      bit_idx <= 3'd0;
      shift   <= 8'd0;
      UartTx  <= 1'b1;
    end else begin
      case (state)
        S_IDLE: begin
          if (start_ok) begin
            state  <= S_START;
            cnt    <= div_q;
            shift  <= fifo_rdata;
            UartTx <= 1'b0;
          end
        end
        S_START: begin
          if (bit_end) begin
            state   <= S_DATA;
            cnt     <= div_q;
            bit_idx <= 3'd0;
            UartTx  <= shift[0];
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_DATA: begin
          if (bit_end) begin
            cnt <= div_q;
            if (bit_idx == 3'd7) begin
              state  <= S_STOP;
              UartTx <= 1'b1;
            end else begin
              bit_idx <= bit_idx + 3'd1;
              shift   <= {1'b0, shift[7:1]};
              UartTx  <= shift[1];
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        S_STOP: begin
          if (bit_end) begin
            if (start_ok) begin
              state  <= S_START;
              cnt    <= div_q;
              shift  <= fifo_rdata;
              UartTx <= 1'b0;
            end else begin
              state  <= S_IDLE;
              UartTx <= 1'b1;
            end
          end else begin
            cnt <= cnt - 8'd1;
          end
        end
        default: begin
          state  <= S_IDLE;
          UartTx <= 1'b1;
        end
      endcase
    end
  end

  // TX-empty interrupt, active low
  always_ff @(posedge MAINCLK or negedge MAINRST) begin
    if (!MAINRST) Irq_n <= 1'b1;
    else          Irq_n <= !(irq_en_q && fifo_empty && (state == S_IDLE));
  end
endmodule

// File: tb/tb_mmio_uart_tx.sv
// tb/tb_mmio_uart_tx.sv - directed/randomised self-checking bench for mmio_uart_tx
module tb_mmio_uart_tx;
  logic clk = 1'b0;
  logic rst_n = 1'b0;
  logic tx;
  logic irq_n;
  int   errors = 0;
  int   checks = 0;

  mmio_uart_tx_if bus ();

  mmio_uart_tx #(.BASE_ADDR(16'hFF00), .FIFO_DEPTH(8), .DEFAULT_DIV(8'd103)) dut (
    .MAINCLK (clk),
    .MAINRST (rst_n),
    .bus     (bus),
    .UartTx  (tx),
    .Irq_n   (irq_n)
  );

  always #5 clk = ~clk;

  initial begin
    #2000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  // Reference model: queue of accepted bytes plus sticky overflow
  logic [7:0] exp_q[$];
  logic       m_ovf = 1'b0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic logic frame_bit(input logic [7:0] b, input int k);
    if (k == 0) return 1'b0;
    if (k >= 9) return 1'b1;
    return b[k-1];
  endfunction

  function automatic logic [7:0] exp_status(input logic busy);
    logic [7:0] s;
    s = 8'h00;
    s[0] = (exp_q.size() == 8);
    s[1] = (exp_q.size() == 0);
    s[2] = busy;
    s[3] = m_ovf;
    return s;
  endfunction

  task automatic wr(input logic [15:0] a, input logic [7:0] d);
    bus.Addr = a;
    bus.MemDataIn = d;
    bus.MemBridge_Direction = 1'b0;
    bus.MemBridge_Load = 1'b0;
    @(negedge clk);
    bus.MemBridge_Load = 1'b1;
    bus.Addr = 16'h0000;
    @(negedge clk);
  endtask

  task automatic push_byte(input logic [7:0] b);
    if (exp_q.size() < 8) exp_q.push_back(b);
    else m_ovf = 1'b1;
    wr(16'hFF00, b);
  endtask

  task automatic rd(input logic [15:0] a, input logic ack, output logic [7:0] d);
    bus.Addr = a;
    bus.MemBridge_Direction = 1'b1;
    bus.Memory_Ack = !ack;
    #1;
    d = bus.MemDataOut;
    check("read_oe", {31'b0, bus.MemDataOE}, 32'd1);
    @(negedge clk);
    bus.Memory_Ack = 1'b1;
    bus.MemBridge_Direction = 1'b0;
    bus.Addr = 16'h0000;
  endtask

  task automatic wait_start(input int limit, output logic found, output int n);
    n = 0;
    while (tx !== 1'b0 && n < limit) begin
      @(negedge clk);
      n++;
    end
    found = (tx === 1'b0);
  endtask

  task automatic check_frame(input logic [7:0] b, input int d, input int flush_at);
    int bad;
    bad = 0;
    for (int i = 0; i < 10 * (d + 1); i++) begin
      if (i > 0) @(negedge clk);
      if (tx !== frame_bit(b, i / (d + 1))) bad++;
      if (flush_at >= 0 && i == flush_at) begin
        bus.Addr = 16'hFF03;
        bus.MemDataIn = 8'h03;
        bus.MemBridge_Direction = 1'b0;
        bus.MemBridge_Load = 1'b0;
      end
      if (flush_at >= 0 && i == flush_at + 1) begin
        bus.MemBridge_Load = 1'b1;
        bus.Addr = 16'h0000;
      end
    end
    check($sformatf("frame_%02h_bad_cycles", b), bad, 0);
  endtask

  initial begin
    logic [7:0] d8;
    logic [7:0] b;
    logic       found;
    int         n;
    int         div;

    bus.Addr = 16'h0000;
    bus.MemDataIn = 8'h00;
    bus.MemBridge_Load = 1'b1;
    bus.MemBridge_Direction = 1'b0;
    bus.Memory_Ack = 1'b1;

    // Reset state
    repeat (3) @(negedge clk);
    check("rst_tx", {31'b0, tx}, 32'd1);
    check("rst_irq", {31'b0, irq_n}, 32'd1);
    bus.MemBridge_Direction = 1'b1;
    #1 check("rst_oe_unsel", {31'b0, bus.MemDataOE}, 32'd0);
    bus.MemBridge_Direction = 1'b0;
    @(negedge clk);
    rst_n = 1'b1;
    @(negedge clk);
    rd(16'hFF02, 1'b0, d8); check("rst_div", d8, 32'd103);
    rd(16'hFF03, 1'b0, d8); check("rst_ctrl", d8, 32'h01);
    rd(16'hFF01, 1'b0, d8); check("rst_status", d8, exp_status(1'b0));
    rd(16'hFF00, 1'b0, d8); check("txdata_read", d8, 32'h00);

    // 1: DIV=3, single 0xA5 frame, 4 clocks per bit
    div = 3;
    wr(16'hFF02, 8'd3);
    rd(16'hFF02, 1'b0, d8); check("div_rw", d8, 32'd3);
    push_byte(8'hA5);
    wait_start(100, found, n); check("t1_start", {31'b0, found}, 32'd1);
    check_frame(exp_q.pop_front(), div, -1);
    @(negedge clk);
    rd(16'hFF01, 1'b0, d8); check("t1_status", d8, 32'h02);

    // 2: strobe held low 10 clocks yields one byte only
    wr(16'hFF03, 8'h00);
    exp_q.push_back(8'h55);
    bus.Addr = 16'hFF00; bus.MemDataIn = 8'h55; bus.MemBridge_Load = 1'b0;
    repeat (10) @(negedge clk);
    bus.MemBridge_Load = 1'b1; bus.Addr = 16'h0000;
    @(negedge clk);
    rd(16'hFF01, 1'b0, d8); check("t2_status_one", d8, exp_status(1'b0));
    wr(16'hFF03, 8'h01);
    wait_start(100, found, n); check("t2_start", {31'b0, found}, 32'd1);
    check_frame(exp_q.pop_front(), div, -1);
    wait_start(60, found, n); check("t2_no_second", {31'b0, found}, 32'd0);
    rd(16'hFF01, 1'b0, d8); check("t2_status", d8, 32'h02);

    // 3: overflow with enable=0, clear by acknowledged STATUS read, then drain
    wr(16'hFF03, 8'h00);
    for (int k = 0; k < 9; k++) push_byte(8'($urandom));
    rd(16'hFF01, 1'b0, d8); check("t3_status_ovf", d8, 32'h09);
    check("t3_model", exp_status(1'b0), 32'h09);
    rd(16'hFF01, 1'b1, d8); check("t3_status_ack", d8, exp_status(1'b0));
    m_ovf = 1'b0;
    rd(16'hFF01, 1'b0, d8); check("t3_status_clr", d8, 32'h01);
    div = $urandom_range(1, 4);
    wr(16'hFF02, 8'(div));
    wr(16'hFF03, 8'h01);
    for (int k = 0; k < 8; k++) begin
      wait_start(100, found, n); check("t3_start", {31'b0, found}, 32'd1);
      if (k > 0) check("t3_gap", n, 32'd1);
      check_frame(exp_q.pop_front(), div, -1);
    end
    wait_start(60, found, n); check("t3_dropped", {31'b0, found}, 32'd0);

    // 4: three back-to-back frames, irq only after the last STOP
    wr(16'hFF03, 8'h00);
    for (int k = 0; k < 3; k++) push_byte(8'($urandom));
    wr(16'hFF03, 8'h05);
    for (int k = 0; k < 3; k++) begin
      wait_start(100, found, n); check("t4_start", {31'b0, found}, 32'd1);
      if (k > 0) check("t4_gap", n, 32'd1);
      check("t4_irq_busy", {31'b0, irq_n}, 32'd1);
      check_frame(exp_q.pop_front(), div, -1);
    end
    @(negedge clk); check("t4_irq_lag", {31'b0, irq_n}, 32'd1);
    @(negedge clk); check("t4_irq_low", {31'b0, irq_n}, 32'd0);
    rd(16'hFF01, 1'b0, d8); check("t4_status", d8, 32'h02);

    // 5: flush mid-frame with 4 bytes still queued
    div = 3;
    wr(16'hFF02, 8'd3);
    wr(16'hFF03, 8'h00);
    for (int k = 0; k < 5; k++) push_byte(8'($urandom));
    wr(16'hFF03, 8'h01);
    wait_start(100, found, n); check("t5_start", {31'b0, found}, 32'd1);
    check_frame(exp_q.pop_front(), div, 15);
    exp_q.delete();
    wait_start(60, found, n); check("t5_idle", {31'b0, found}, 32'd0);
    rd(16'hFF01, 1'b0, d8); check("t5_status", d8, 32'h02);

    // 6: asynchronous reset in the middle of DATA (bit 2 forced low)
    b = 8'($urandom) & 8'hFB;
    push_byte(b);
    wait_start(100, found, n); check("t6_start", {31'b0, found}, 32'd1);
    repeat (3 * (div + 1) + 1) @(negedge clk);
    check("t6_pre_low", {31'b0, tx}, 32'd0);
    #1 rst_n = 1'b0;
    #1;
    check("t6_tx_async", {31'b0, tx}, 32'd1);
    check("t6_irq", {31'b0, irq_n}, 32'd1);
    bus.Addr = 16'h1234; bus.MemBridge_Direction = 1'b1;
    #1 check("t6_oe_unsel", {31'b0, bus.MemDataOE}, 32'd0);
    bus.MemBridge_Direction = 1'b0; bus.Addr = 16'h0000;
    @(negedge clk);
    rst_n = 1'b1;
    exp_q.delete();
    m_ovf = 1'b0;
    @(negedge clk);
    rd(16'hFF02, 1'b0, d8); check("t6_div", d8, 32'd103);
    rd(16'hFF03, 1'b0, d8); check("t6_ctrl", d8, 32'h01);
    rd(16'hFF01, 1'b0, d8); check("t6_status", d8, exp_status(1'b0));
    check("t6_tx_idle", {31'b0, tx}, 32'd1);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
